// File: rtl/vec_pkg.sv
// Shared types and constants for the reset/interrupt vector sequencer.
package vec_pkg;

   // Sequencer states: hold after reset, wait for a source, fetch the two vector bytes.
   typedef enum logic [1:0] {
      ST_RST_HOLD = 2'd0,
      ST_IDLE     = 2'd1,
      ST_FETCH_LO = 2'd2,
      ST_FETCH_HI = 2'd3
   } state_e;

   // Source codes as seen on the src port.
   typedef enum logic [1:0] {
      SRC_RESET = 2'd0,
      SRC_NMI   = 2'd1,
      SRC_BRK   = 2'd2,
      SRC_IRQ   = 2'd3
   } src_e;

   localparam logic [15:0] VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] VEC_RESET = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ   = 16'hFFFE;  // shared by BRK and IRQ

   // Low-byte address of the vector belonging to a source.
   function automatic logic [15:0] vec_base(input src_e s);
      case (s)
         SRC_NMI:   vec_base = VEC_NMI;
         SRC_RESET: vec_base = VEC_RESET;
         default:   vec_base = VEC_IRQ;
      endcase
   endfunction

endpackage

// File: rtl/edge_latch.sv
// Rising-edge detector with a sticky pending flag. A new edge wins over a
// same-cycle clear so that no edge is ever lost. The previous-sample register
// resets to 1 so a line already high when reset releases is not seen as an edge.
module edge_latch (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   input  logic clr,
   output logic pend
);

   logic prev_q;
   logic pend_q, pend_d;

   // Set on a 0->1 transition, otherwise hold until cleared.
   always_comb begin
      pend_d = (sig & ~prev_q) | (pend_q & ~clr);
   end

   // Sample history and pending flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b1;
         pend_q <= 1'b0;
      end else begin
         prev_q <= sig;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/vector_seq.sv
// Reset/NMI/BRK/IRQ vector sequencer. Picks a source at an instruction
// boundary and fetches the two vector bytes into the PC.
//
// Memory handshake: while in a fetch state the sequencer holds mem_rd=1 and a
// stable mem_addr; a byte is taken in the same cycle mem_ready=1 is seen with
// mem_rd=1 (mem_rdata is then valid), and there is no bound on how long
// mem_ready may stay low. pc_data is mem_rdata passed straight through.
module vector_seq
   import vec_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nmi,
   input  logic        irq,
   input  logic        irq_mask,
   input  logic        brk_req,
   input  logic        boundary,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        load_pc_l,
   output logic        load_pc_h,
   output logic [7:0]  pc_data,
   output logic        busy,
   output logic [1:0]  src,
   output logic        done,
   output logic        set_i
);

   state_e state_q, state_d;
   src_e   src_q, src_d;
   logic   brk_pend_q, brk_pend_d;

   logic nmi_pend, nmi_clr;
   logic irq_live, dispatch, brk_take;
   logic fetch_lo, fetch_hi;

   edge_latch u_nmi_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (nmi),
      .clr   (nmi_clr),
      .pend  (nmi_pend)
   );

   // IRQ is a live level, never remembered.
   assign irq_live = irq & ~irq_mask;
   assign dispatch = (state_q == ST_IDLE) & boundary & (nmi_pend | brk_pend_q | irq_live);
   assign nmi_clr  = dispatch & nmi_pend;
   assign brk_take = dispatch & ~nmi_pend & brk_pend_q;

   // Next state and source selection; priority NMI > BRK > IRQ.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      case (state_q)
         ST_RST_HOLD: begin
            state_d = ST_FETCH_LO;
            src_d   = SRC_RESET;
         end
         ST_IDLE: begin
            if (dispatch) begin
               state_d = ST_FETCH_LO;
               if (nmi_pend)        src_d = SRC_NMI;
               else if (brk_pend_q) src_d = SRC_BRK;
               else                 src_d = SRC_IRQ;
            end
         end
         ST_FETCH_LO: if (mem_ready) state_d = ST_FETCH_HI;
         ST_FETCH_HI: if (mem_ready) state_d = ST_IDLE;
         default:     state_d = ST_RST_HOLD;
      endcase
   end

   // A new BRK request wins over a same-cycle clear.
   always_comb begin
      brk_pend_d = brk_req | (brk_pend_q & ~brk_take);
   end

   // State, latched source and BRK pending flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RST_HOLD;
         src_q      <= SRC_RESET;
         brk_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         brk_pend_q <= brk_pend_d;
      end
   end

   assign fetch_lo = (state_q == ST_FETCH_LO);
   assign fetch_hi = (state_q == ST_FETCH_HI);

   assign mem_addr  = vec_base(src_q) + {15'd0, fetch_hi};
   assign mem_rd    = fetch_lo | fetch_hi;
   assign load_pc_l = fetch_lo & mem_ready;
   assign load_pc_h = fetch_hi & mem_ready;
   assign done      = load_pc_h;
   assign set_i     = load_pc_h;
   assign busy      = (state_q != ST_IDLE);
   assign pc_data   = mem_rdata;
   assign src       = src_q;

endmodule

// File: tb/tb_vector_seq.sv
// Bench for vector_seq: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_vector_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        nmi, irq, irq_mask, brk_req, boundary, mem_ready;
   logic [7:0]  mem_rdata;
   logic [15:0] mem_addr;
   logic        mem_rd, load_pc_l, load_pc_h, busy, done, set_i;
   logic [7:0]  pc_data;
   logic [1:0]  src;

   logic [7:0]  vt [8];          // vector ROM, FFF8..FFFF by low address bits
   int          checks = 0;
   int          errors = 0;
   bit          run_chk = 1'b0;
   logic [23:0] exp_q [$];        // expected {address, byte} of each PC load
   logic [1:0]  dut_src_log [$];  // src seen at every DUT done pulse

   vector_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .nmi       (nmi),
      .irq       (irq),
      .irq_mask  (irq_mask),
      .brk_req   (brk_req),
      .boundary  (boundary),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .load_pc_l (load_pc_l),
      .load_pc_h (load_pc_h),
      .pc_data   (pc_data),
      .busy      (busy),
      .src       (src),
      .done      (done),
      .set_i     (set_i)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   // Memory: vector bytes at FFF8..FFFF, zero elsewhere.
   always_comb begin
      mem_rdata = 8'h00;
      if (mem_addr[15:3] == 13'h1FFF) mem_rdata = vt[mem_addr[2:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] vbase(input logic [1:0] s);
      if (s == 2'd1)      vbase = 16'hFFFA;
      else if (s == 2'd0) vbase = 16'hFFFC;
      else                vbase = 16'hFFFE;
   endfunction

   // ---------------- reference model ----------------
   // Tracks: holding after reset, an active two-byte fetch (which byte, which
   // source), and the remembered NMI/BRK events.
   bit         m_hold, m_active, m_byte, m_nmi_pend, m_nmi_prev, m_brk_pend;
   logic [1:0] m_src;

   wire m_can   = !m_hold && !m_active && boundary;
   wire m_t_nmi = m_can && m_nmi_pend;
   wire m_t_brk = m_can && !m_nmi_pend && m_brk_pend;
   wire m_t_irq = m_can && !m_nmi_pend && !m_brk_pend && irq && !irq_mask;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold     <= 1'b1;
         m_active   <= 1'b0;
         m_byte     <= 1'b0;
         m_src      <= 2'd0;
         m_nmi_pend <= 1'b0;
         m_nmi_prev <= 1'b1;
         m_brk_pend <= 1'b0;
      end else begin
         m_nmi_prev <= nmi;
         m_nmi_pend <= (nmi && !m_nmi_prev) || (m_nmi_pend && !m_t_nmi);
         m_brk_pend <= brk_req || (m_brk_pend && !m_t_brk);
         if (m_hold) begin
            m_hold <= 1'b0; m_active <= 1'b1; m_byte <= 1'b0; m_src <= 2'd0;
         end else if (m_active) begin
            if (mem_ready) begin
               if (!m_byte) m_byte <= 1'b1;
               else         m_active <= 1'b0;
            end
         end else if (m_t_nmi || m_t_brk || m_t_irq) begin
            m_active <= 1'b1;
            m_byte   <= 1'b0;
            m_src    <= m_t_nmi ? 2'd1 : (m_t_brk ? 2'd2 : 2'd3);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin : cmp
         logic        e_busy, e_rd, e_ll, e_lh;
         logic [15:0] e_addr;
         logic [1:0]  e_src;
         @(negedge clk);
         if (run_chk) begin
            e_busy = 1'b0; e_rd = 1'b0; e_ll = 1'b0; e_lh = 1'b0;
            e_addr = 16'hFFFC; e_src = 2'd0;
            if (m_hold) begin
               e_busy = 1'b1;
            end else if (m_active) begin
               e_busy = 1'b1;
               e_rd   = 1'b1;
               e_addr = vbase(m_src) + {15'd0, m_byte};
               e_ll   = mem_ready && !m_byte;
               e_lh   = mem_ready && m_byte;
               e_src  = m_src;
            end
            chk("busy", busy, e_busy);
            chk("mem_rd", mem_rd, e_rd);
            chk("load_pc_l", load_pc_l, e_ll);
            chk("load_pc_h", load_pc_h, e_lh);
            chk("done", done, e_lh);
            chk("set_i", set_i, e_lh);
            chk("pc_data_pass", pc_data, mem_rdata);
            chk("load_excl", load_pc_l & load_pc_h, 1'b0);
            if (e_busy) begin
               chk("mem_addr", mem_addr, e_addr);
               chk("src", src, e_src);
            end
            if (e_ll || e_lh) exp_q.push_back({e_addr, vt[e_addr[2:0]]});
            if (load_pc_l || load_pc_h) begin
               if (exp_q.size() == 0) chk("sb_unexpected_load", 1'b1, 1'b0);
               else                   chk("sb_load", {mem_addr, pc_data}, exp_q.pop_front());
            end
            if (done) dut_src_log.push_back(src);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max_cyc, output logic [15:0] a,
                            output logic [7:0] d, output logic [1:0] s);
      bit seen = 1'b0;
      a = '0; d = '0; s = '0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1; a = mem_addr; d = pc_data; s = src;
         end
      end
      chk("wait_done_timeout", seen, 1'b1);
   endtask

   task automatic wait_busy(input int max_cyc);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("wait_busy_timeout", seen, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      logic [1:0]  s;
      int          base;

      nmi = 0; irq = 0; irq_mask = 0; brk_req = 0; boundary = 0; mem_ready = 1;
      vt[0] = 8'h00; vt[1] = 8'h00;
      vt[2] = 8'hAB; vt[3] = 8'hCD;   // NMI  FFFA/FFFB
      vt[4] = 8'h34; vt[5] = 8'h12;   // RESET FFFC/FFFD
      vt[6] = 8'hEF; vt[7] = 8'h89;   // BRK/IRQ FFFE/FFFF

      #1 rst_n = 0;
      repeat (2) @(posedge clk);
      run_chk = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 1'b1);
      chk("rst_addr", mem_addr, 16'hFFFC);
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_done", done, 1'b0);

      // Reset release with memory always ready
      tick(); rst_n = 1;
      @(negedge clk); chk("c1_load_l", load_pc_l, 1'b0); chk("c1_busy", busy, 1'b1);
      @(negedge clk); chk("c2_load_l", load_pc_l, 1'b1); chk("c2_pc", pc_data, 8'h34);
      @(negedge clk); chk("c3_load_h", load_pc_h, 1'b1); chk("c3_done", done, 1'b1);
                      chk("c3_pc", pc_data, 8'h12);
      @(negedge clk); chk("c4_idle", busy, 1'b0);

      // NMI pulse plus live IRQ: NMI first, then IRQ
      tick(); nmi = 1;
      tick(); nmi = 0; irq = 1; irq_mask = 0; boundary = 1;
      wait_done(20, a, d, s);
      chk("nmi_src", s, 2'd1); chk("nmi_addr", a, 16'hFFFB); chk("nmi_pc", d, 8'hCD);
      wait_done(20, a, d, s);
      chk("irq_src", s, 2'd3); chk("irq_addr", a, 16'hFFFF); chk("irq_pc", d, 8'h89);

      // BRK with memory stalled 5 cycles in the low-byte fetch
      tick(); irq = 0; boundary = 0; mem_ready = 0; brk_req = 1;
      tick(); brk_req = 0; boundary = 1;
      wait_busy(10);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_addr", mem_addr, 16'hFFFE);
         chk("stall_rd", mem_rd, 1'b1);
         chk("stall_load_l", load_pc_l, 1'b0);
         chk("stall_load_h", load_pc_h, 1'b0);
      end
      tick(); mem_ready = 1;
      @(negedge clk); chk("stall_end_load_l", load_pc_l, 1'b1); chk("stall_end_pc", pc_data, 8'hEF);
      @(negedge clk); chk("stall_one_load_l", load_pc_l, 1'b0); chk("stall_done", done, 1'b1);

      // NMI raised and held high during a BRK fetch
      tick(); mem_ready = 0; brk_req = 1; boundary = 0;
      tick(); brk_req = 0; boundary = 1; base = dut_src_log.size();
      tick(); nmi = 1;
      for (int i = 0; i < 20; i++) begin
         tick(); mem_ready = 1'($urandom_range(0, 1));
      end
      tick(); nmi = 0; mem_ready = 1;
      repeat (30) tick();
      chk("held_nmi_dispatches", dut_src_log.size() - base, 2);
      if (dut_src_log.size() >= base + 2) begin
         chk("held_first_brk", dut_src_log[base], 2'd2);
         chk("held_then_nmi", dut_src_log[base + 1], 2'd1);
      end

      // Reset during the high-byte fetch of an IRQ
      tick(); irq = 1; irq_mask = 0; mem_ready = 0;
      wait_busy(10);
      tick(); mem_ready = 1;
      @(negedge clk); chk("abort_lo_load", load_pc_l, 1'b1);
      tick(); mem_ready = 0; irq = 0;
      @(negedge clk); chk("abort_hi_wait", load_pc_h, 1'b0); chk("abort_hi_addr", mem_addr, 16'hFFFF);
      tick(); rst_n = 0;
      @(negedge clk);
      chk("abort_load_h", load_pc_h, 1'b0);
      chk("abort_addr", mem_addr, 16'hFFFC);
      chk("abort_rd", mem_rd, 1'b0);
      tick(); rst_n = 1; mem_ready = 1;
      wait_done(10, a, d, s);
      chk("refetch_src", s, 2'd0); chk("refetch_addr", a, 16'hFFFD); chk("refetch_pc", d, 8'h12);

      // Masked IRQ must not dispatch; unmasking does
      tick(); irq = 1; irq_mask = 1;
      repeat (5) begin
         @(negedge clk); chk("masked_busy", busy, 1'b0);
      end
      tick(); irq_mask = 0;
      wait_done(10, a, d, s);
      chk("unmask_src", s, 2'd3);
      tick(); irq = 0; boundary = 0;

      // Randomized traffic
      for (int k = 2; k < 8; k++) vt[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 600; i++) begin
         tick();
         if ($urandom_range(0, 15) == 0) nmi = ~nmi;
         irq       = ($urandom_range(0, 3) == 0);
         irq_mask  = 1'($urandom_range(0, 1));
         brk_req   = ($urandom_range(0, 15) == 0);
         boundary  = ($urandom_range(0, 2) != 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 199) != 0);
      end
      tick(); rst_n = 1; mem_ready = 1; brk_req = 0;
      repeat (10) tick();
      chk("sb_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_seq.md
VECTOR_SEQ -- requirements
Module: vector_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- nmi  in  1  NMI line, active high, rising-edge sensitive
- irq  in  1  IRQ line, active high, level sensitive
- irq_mask  in  1  I flag; 1 blocks irq
- brk_req  in  1  one-cycle BRK pulse from decoder
- boundary  in  1  instruction boundary; dispatch permitted
- mem_rdata  in  8  read data
- mem_ready  in  1  read data valid this cycle
- mem_addr  out  16  vector byte address
- mem_rd  out  1  read request
- load_pc_l  out  1  load PC low byte from pc_data
- load_pc_h  out  1  load PC high byte from pc_data
- pc_data  out  8  byte to PC, equals mem_rdata
- busy  out  1  sequence in progress
- src  out  2  active source: 0 RESET, 1 NMI, 2 BRK, 3 IRQ
- done  out  1  one-cycle completion pulse
- set_i  out  1  set I flag, equals done

Function
REQ-003 SHALL implement the FSM states RST_HOLD, IDLE, FETCH_LO and FETCH_HI.
REQ-004 RST_HOLD SHALL go to FETCH_LO on the next clk with src=RESET, unconditionally.
REQ-005 IDLE SHALL go to FETCH_LO when boundary=1 and any source is pending, choosing by priority NMI > BRK > IRQ and latching src.
REQ-006 Vector base SHALL be FFFA for NMI, FFFC for RESET, and FFFE for BRK and IRQ.
REQ-007 FETCH_LO SHALL drive mem_addr=base and mem_rd=1; on mem_ready it SHALL drive load_pc_l=1 that cycle and go to FETCH_HI.
REQ-008 FETCH_HI SHALL drive mem_addr=base+1 and mem_rd=1; on mem_ready it SHALL drive load_pc_h=1, done=1 and set_i=1 that cycle and go to IDLE.
REQ-009 While mem_ready=0, the FSM SHALL hold state and all outputs stable; the wait length is unbounded.
REQ-010 load_pc_l and load_pc_h SHALL never both be 1 in the same cycle.
REQ-011 pc_data SHALL be combinationally equal to mem_rdata.
REQ-012 busy SHALL be 1 in every state except IDLE; mem_rd SHALL be 0 in RST_HOLD and IDLE.
REQ-013 Pending NMI: on a rising edge of nmi (previous sample 0, current 1) the flag SHALL set; it SHALL clear only in the cycle NMI is dispatched.
REQ-014 An NMI edge arriving during busy SHALL stay pending and be dispatched at the first boundary in IDLE.
REQ-015 A held-high nmi SHALL produce exactly one dispatch.
REQ-016 Pending BRK: brk_req=1 SHALL set the flag; it SHALL clear on BRK dispatch.
REQ-017 IRQ SHALL be pending when irq=1 and irq_mask=0, sampled live at dispatch and never latched.
REQ-018 If an NMI edge and a dispatch of another source fall in the same cycle, the NMI SHALL set its flag and win the next dispatch.
REQ-019 If boundary=1 in IDLE with nothing pending, the FSM SHALL stay in IDLE.

Reset
REQ-020 rst_n=0 SHALL, asynchronously and in any state, force state=RST_HOLD, src=RESET, clear the NMI and BRK pending flags, and set the nmi previous-sample register to 1.
REQ-021 While rst_n=0, outputs SHALL be: mem_rd=0, load_pc_l=0, load_pc_h=0, done=0, set_i=0, busy=1, mem_addr=FFFC.
REQ-022 Reset mid-sequence SHALL abort the sequence without issuing a load pulse, and the RESET fetch SHALL restart after release.

Structure
REQ-023 A shared package vec_pkg SHALL hold the state enum, the src enum and the vector constants FFFA, FFFC and FFFE.
REQ-024 Rising-edge detection with the pending flag SHALL be a sub-module, edge_latch (inputs: clk, rst_n, sig, clr; output: pend), instantiated for nmi.
REQ-025 The implementation SHALL be one registered FSM with combinational output decode and no latches.

Verification
REQ-026 Release rst_n with mem_ready=1, FFFC=34 and FFFD=12: load_pc_l with 34 on cycle 2, load_pc_h with 12 on cycle 3, done on cycle 3, then IDLE.
REQ-027 In IDLE, pulse nmi, set irq=1 and irq_mask=0, then boundary=1: NMI fetch from FFFA/FFFB first; after done and another boundary, IRQ fetch from FFFE/FFFF.
REQ-028 Hold mem_ready=0 for 5 cycles in FETCH_LO: mem_addr and mem_rd stable and no load pulses; ready on cycle 6 gives exactly one load_pc_l.
REQ-029 Pulse nmi during a BRK fetch, holding nmi high for 20 cycles: exactly one NMI dispatch after BRK done.
REQ-030 Assert rst_n=0 in FETCH_HI of an IRQ fetch: no load_pc_h; after release, a RESET fetch from FFFC.
REQ-031 irq=1 with irq_mask=1 and boundary=1: no dispatch and busy stays 0; dropping irq_mask gives dispatch on the next boundary.
